// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler time-sharing one external 32-bit adder between NREQ requesters.
// Optional `OVERFLOW_FLAG_EN adds a registered two's-complement overflow flag (rsp_ovf).
module adder_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic [31:0]       add_a,
    output logic [31:0]       add_b,
    output logic              add_cin,
    input  logic [31:0]       add_s,
    input  logic              add_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_sum,
    output logic              rsp_cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic              rsp_ovf
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [31:0]    add_a_q, add_a_d;
    logic [31:0]    add_b_q, add_b_d;
    logic           add_cin_q, add_cin_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [31:0]    rsp_sum_q, rsp_sum_d;
    logic           rsp_cout_q, rsp_cout_d;
`ifdef OVERFLOW_FLAG_EN
    logic           rsp_ovf_q, rsp_ovf_d;
`endif

    logic [31:0] op_a [NREQ];
    logic [31:0] op_b [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_split
        assign op_a[g] = req_a[32*g +: 32];
        assign op_b[g] = req_b[32*g +: 32];
    end

    // Rotating priority search: first valid requester at or after the pointer.
    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [IDW:0]   cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
            if (!win_found && req_valid[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
`ifdef OVERFLOW_FLAG_EN
        rsp_ovf_d   = rsp_ovf_q;
`endif
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                // Ready is combinational, so it must be masked while reset is held.
                if (win_found && !rst) begin
                    req_ready[win_idx] = 1'b1;
                    add_a_d   = op_a[win_idx];
                    add_b_d   = op_b[win_idx];
                    add_cin_d = req_cin[win_idx];
                    id_d      = win_idx;
                    ptr_d     = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_sum_d   = add_s;
                rsp_cout_d  = add_cout;
`ifdef OVERFLOW_FLAG_EN
                rsp_ovf_d   = (add_a_q[31] == add_b_q[31]) && (add_s[31] != add_a_q[31]);
`endif
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            rsp_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
`ifdef OVERFLOW_FLAG_EN
            rsp_ovf_q   <= rsp_ovf_d;
`endif
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
`ifdef OVERFLOW_FLAG_EN
    assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: directed vector table, corner sequences, and a random run
// against a transaction-level timeline model of the scheduler.
module tb_adder_rr_scheduler;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a, req_b;
    logic [NREQ-1:0]      req_cin;
    logic [31:0]          add_a, add_b, add_s;
    logic                 add_cin, add_cout;
    logic                 rsp_valid, rsp_ready, rsp_cout;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_sum;
`ifdef OVERFLOW_FLAG_EN
    logic                 rsp_ovf;
`endif

    int total = 0;
    int bad   = 0;

    adder_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
`ifdef OVERFLOW_FLAG_EN
        , .rsp_ovf(rsp_ovf)
`endif
    );

    // External shared adder
    logic [32:0] add_full;
    assign add_full = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};
    assign add_s    = add_full[31:0];
    assign add_cout = add_full[32];

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic cin);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_cin[id] = cin;
    endtask

    task automatic do_op(input vec_t v);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[v.id] = 1'b1;
        req_valid = oh;
        set_op(v.id, v.a, v.b, v.cin);
        rsp_ready = 1'b0;
        #1 chk("vec_ready", req_ready, oh);
        @(negedge clk);
        req_valid = '0;
        req_a = {$urandom, $urandom, $urandom, $urandom};
        req_b = {$urandom, $urandom, $urandom, $urandom};
        req_cin = 4'($urandom);
        #1;
        chk("vec_add_a", add_a, v.a);
        chk("vec_add_b", add_b, v.b);
        chk("vec_exec_valid", rsp_valid, 0);
        chk("vec_exec_ready", req_ready, 0);
        @(negedge clk);
        #1;
        chk("vec_rsp_valid", rsp_valid, 1);
        chk("vec_rsp_id", rsp_id, v.id);
        chk("vec_rsp_sum", rsp_sum, v.exp_sum);
        chk("vec_rsp_cout", rsp_cout, v.exp_cout);
`ifdef OVERFLOW_FLAG_EN
        chk("vec_rsp_ovf", rsp_ovf, v.exp_ovf);
`endif
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1 chk("vec_rsp_drop", rsp_valid, 0);
    endtask

    int          gcyc [5];
    int          gid  [5];
    int          ngr;
    int          m_ptr, m_vfrom, w;
    bit          m_busy;
    logic [NREQ-1:0] exp_ready;
    logic        exp_rv;
    int          e_id;
    logic [31:0] e_sum;
    logic        e_cout, e_ovf;
    logic [32:0] t33;

    initial begin
        vecs[0] = '{0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
        vecs[1] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b1, 1'b0};
        vecs[2] = '{2, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        vecs[3] = '{3, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[4] = '{0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        vecs[5] = '{3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[6] = '{1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};

        // Reset values with every requester asking
        rst = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b0;
        req_a = '1;
        req_b = '1;
        req_cin = '1;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_add_cin", add_cin, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_cout", rsp_cout, 0);
        do_reset();

        foreach (vecs[i]) do_op(vecs[i]);

        // All requesters continuously valid: grants 0,1,2,3,0 every 3 cycles
        do_reset();
        rsp_ready = 1'b1;
        req_valid = '1;
        ngr = 0;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (req_ready != 0) begin
                if (ngr < 5) begin
                    gcyc[ngr] = c;
                    for (int k = 0; k < NREQ; k++) if (req_ready[k]) gid[ngr] = k;
                end
                ngr++;
            end
            @(negedge clk);
        end
        chk("rr_grant_count", ngr, 5);
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant_cycle", gcyc[k], 3 * k);
            chk("rr_grant_id", gid[k], k % NREQ);
        end

        // Backpressure: response held for 5 cycles, no grants meanwhile
        do_reset();
        req_valid = 4'b0100;
        set_op(2, 32'hA5A5_0000, 32'h5A5A_FFFF, 1'b1);
        #1 chk("bp_ready", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = 4'b1011;
        #1 chk("bp_exec_ready", req_ready, 0);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_id", rsp_id, 2);
            chk("bp_sum", rsp_sum, 0);
            chk("bp_cout", rsp_cout, 1);
            chk("bp_no_ready", req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("bp_drop", rsp_valid, 0);
        chk("bp_next_grant", req_ready, 4'b1000);

        // Reset during EXEC aborts the operation; pointer returns to 0
        do_reset();
        req_valid = 4'b0010;
        set_op(1, 32'hDEAD_BEEF, 32'h0101_0101, 1'b1);
        set_op(0, 32'h0000_0010, 32'h0000_0020, 1'b0);
        #1 chk("abort_ready", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = 4'b1001;
        #1;
        rst = 1'b1;
        #1;
        chk("abort_ready0", req_ready, 0);
        chk("abort_add_a", add_a, 0);
        chk("abort_add_b", add_b, 0);
        chk("abort_add_cin", add_cin, 0);
        chk("abort_valid", rsp_valid, 0);
        chk("abort_id", rsp_id, 0);
        chk("abort_sum", rsp_sum, 0);
        chk("abort_cout", rsp_cout, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_first_win", req_ready, 4'b0001);
        chk("abort_no_rsp", rsp_valid, 0);
        @(negedge clk);
        req_valid = '0;
        #1 chk("abort_exec_valid", rsp_valid, 0);
        @(negedge clk);
        #1;
        chk("abort_rsp_valid", rsp_valid, 1);
        chk("abort_rsp_id", rsp_id, 0);
        chk("abort_rsp_sum", rsp_sum, 32'h0000_0030);

        // Random traffic against a timeline model
        do_reset();
        m_ptr = 0;
        m_busy = 0;
        m_vfrom = 0;
        e_id = 0; e_sum = '0; e_cout = 0; e_ovf = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid = 4'($urandom);
            for (int j = 0; j < NREQ; j++) begin
                set_op(j, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
                       ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom,
                       1'($urandom));
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            w = -1;
            if (!m_busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                end
            end
            exp_ready = '0;
            if (w >= 0) exp_ready[w] = 1'b1;
            chk("rnd_ready", req_ready, exp_ready);
            exp_rv = m_busy && (cyc >= m_vfrom);
            chk("rnd_valid", rsp_valid, exp_rv);
            if (exp_rv) begin
                chk("rnd_id", rsp_id, e_id);
                chk("rnd_sum", rsp_sum, e_sum);
                chk("rnd_cout", rsp_cout, e_cout);
`ifdef OVERFLOW_FLAG_EN
                chk("rnd_ovf", rsp_ovf, e_ovf);
`endif
                if (rsp_ready) m_busy = 0;
            end
            if (w >= 0) begin
                t33 = {1'b0, req_a[32*w +: 32]} + {1'b0, req_b[32*w +: 32]} + {32'b0, req_cin[w]};
                e_id   = w;
                e_sum  = t33[31:0];
                e_cout = t33[32];
                e_ovf  = (req_a[32*w+31] == req_b[32*w+31]) && (t33[31] != req_a[32*w+31]);
                m_busy = 1;
                m_vfrom = cyc + 2;
                m_ptr = (w + 1) % NREQ;
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
